// File: rtl/cache_pkg.sv
// Shared types, geometry constants and address helpers for the cache refill path.
// Byte address layout: tag [15:10], set [9:4], word [3:1], byte [0].
package cache_pkg;
   localparam int NUM_SETS      = 64;
   localparam int WORDS_PER_BLK = 8;
   localparam int TAG_W         = 6;
   localparam int SET_W         = 6;
   localparam int OFF_W         = 3;
   localparam int ADDR_W        = 16;
   localparam int DATA_W        = 16;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} fill_state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[15:10];
   endfunction

   function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_W-1:0] a);
      return a[9:4];
   endfunction

   function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_W-1:0] t,
                                                   input logic [SET_W-1:0] s,
                                                   input logic [OFF_W-1:0] w);
      return {t, s, w, 1'b0};
   endfunction
endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Bundle between the refill sequencer and its neighbours: miss logic, main memory,
// data/tag arrays, plus a debug view of the FSM state.
interface cache_fill_ctrl_if;
   import cache_pkg::*;

   // Memory side has no backpressure: mem_read_en is a one-cycle request strobe,
   // and each cycle with mem_data_valid = 1 carries exactly one word, in request order.
   logic                     miss_detected;
   logic [ADDR_W-1:0]        miss_address;
   logic                     victim_way;
   logic                     mem_data_valid;
   logic [DATA_W-1:0]        mem_data;
   logic                     mem_read_en;
   logic [ADDR_W-1:0]        mem_address;
   logic [DATA_W-1:0]        data_out;
   logic                     data_wen_w1;
   logic                     data_wen_w2;
   logic [NUM_SETS-1:0]      block_enable;
   logic [WORDS_PER_BLK-1:0] word_enable;
   logic                     tag_wen_w1;
   logic                     tag_wen_w2;
   logic [TAG_W-1:0]         tag_out;
   logic                     fsm_busy;
   logic                     fill_done;
   fill_state_t              fsm_state;

   modport master (
      input  miss_detected, miss_address, victim_way, mem_data_valid, mem_data,
      output mem_read_en, mem_address, data_out, data_wen_w1, data_wen_w2,
             block_enable, word_enable, tag_wen_w1, tag_wen_w2, tag_out,
             fsm_busy, fill_done, fsm_state
   );

   modport slave (
      output miss_detected, miss_address, victim_way, mem_data_valid, mem_data,
      input  mem_read_en, mem_address, data_out, data_wen_w1, data_wen_w2,
             block_enable, word_enable, tag_wen_w1, tag_wen_w2, tag_out,
             fsm_busy, fill_done, fsm_state
   );
endinterface

// File: rtl/onehot_dec.sv
// N-to-2^N one-hot decoder with an enable; all zeros when disabled.
module onehot_dec #(
   parameter int N = 3
) (
   input  logic [N-1:0]      i_idx,
   input  logic              i_en,
   output logic [(2**N)-1:0] o_onehot
);
   always_comb begin
      o_onehot = '0;
      if (i_en) o_onehot[i_idx] = 1'b1;
   end
endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-refill sequencer: issues 8 word reads, steers returns into the victim way,
// then writes the tag and pulses fill_done.
module cache_fill_ctrl
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cache_fill_ctrl_if.master  bus
);
   localparam logic [OFF_W-1:0] LAST_REQ = OFF_W'(WORDS_PER_BLK - 1);
   localparam logic [OFF_W:0]   FULL_CNT = (OFF_W+1)'(WORDS_PER_BLK);
   localparam logic [OFF_W:0]   LAST_RET = (OFF_W+1)'(WORDS_PER_BLK - 1);

   fill_state_t       r_state;
   fill_state_t       w_next;
   logic [TAG_W-1:0]  r_tag;
   logic [SET_W-1:0]  r_set;
   logic              r_way;
   logic [OFF_W-1:0]  r_req_cnt;
   logic [OFF_W:0]    r_ret_cnt;
   logic              w_filling;
   logic              w_ret_ok;
   logic              w_last_ret;

   // A return only writes while a fill is open and fewer than 8 words have landed.
   assign w_filling  = (r_state == REQ) || (r_state == WAIT);
   assign w_ret_ok   = w_filling && bus.mem_data_valid && (r_ret_cnt < FULL_CNT);
   assign w_last_ret = w_ret_ok && (r_ret_cnt == LAST_RET);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_tag     <= '0;
         r_set     <= '0;
         r_way     <= 1'b0;
         r_req_cnt <= '0;
         r_ret_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && bus.miss_detected) begin
            r_tag     <= addr_tag(bus.miss_address);
            r_set     <= addr_set(bus.miss_address);
            r_way     <= bus.victim_way;
            r_req_cnt <= '0;
            r_ret_cnt <= '0;
         end
         if (r_state == REQ) r_req_cnt <= r_req_cnt + 1'b1;
         if (w_ret_ok)       r_ret_cnt <= r_ret_cnt + 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.miss_detected) w_next = REQ;
         // The last request may coincide with the last return only at 1-cycle latency.
         REQ:     if (r_req_cnt == LAST_REQ) w_next = w_last_ret ? DONE : WAIT;
         WAIT:    if (r_ret_cnt == FULL_CNT) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_read_en = (r_state == REQ);
      bus.mem_address = (r_state == REQ) ? make_addr(r_tag, r_set, r_req_cnt) : '0;
      bus.data_out    = w_ret_ok ? bus.mem_data : '0;
      bus.data_wen_w1 = w_ret_ok && !r_way;
      bus.data_wen_w2 = w_ret_ok && r_way;
      bus.tag_wen_w1  = (r_state == DONE) && !r_way;
      bus.tag_wen_w2  = (r_state == DONE) && r_way;
      bus.tag_out     = (r_state == DONE) ? r_tag : '0;
      bus.fsm_busy    = (r_state != IDLE);
      bus.fill_done   = (r_state == DONE);
      bus.fsm_state   = r_state;
   end

   onehot_dec #(.N(SET_W)) u_set_dec (
      .i_idx    (r_set),
      .i_en     (w_ret_ok),
      .o_onehot (bus.block_enable)
   );

   onehot_dec #(.N(OFF_W)) u_word_dec (
      .i_idx    (r_ret_cnt[OFF_W-1:0]),
      .i_en     (w_ret_ok),
      .o_onehot (bus.word_enable)
   );
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: reactive memory model with configurable latency and
// return gaps, checked against expectations derived from the miss address and way.
module tb_cache_fill_ctrl;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   logic [15:0] exp_q[$];

   cache_fill_ctrl_if bus();

   cache_fill_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One fill: miss presented in the current cycle (start), then one loop pass per cycle.
   // Returns are requested words in order; word k is available lat-1 cycles after its request.
   task automatic do_fill(input logic [15:0] addr, input logic way, input int lat,
                          input int gap_mode, input bit hold_miss, input logic [15:0] alt_addr,
                          input int rst_after, output int done_at);
      logic [15:0] pend_a[$];
      int          pend_t[$];
      logic [15:0] a;
      logic [15:0] ra;
      logic [6:0]  gap_pat;
      int          nret;
      int          exp_done;
      int          rc;
      bit          done;
      bit          aborted;
      bit          gate;
      gap_pat  = 7'b1011001;
      nret     = 0;
      exp_done = -1;
      done     = 1'b0;
      aborted  = 1'b0;
      done_at  = -1;
      ra       = '0;
      exp_q.delete();
      for (int k = 0; k < 8; k++) exp_q.push_back({addr[15:4], 3'(k), 1'b0});
      bus.miss_detected = 1'b1;
      bus.miss_address  = addr;
      bus.victim_way    = way;
      @(posedge clk);
      for (rc = 0; rc < 60 && !done && !aborted; rc++) begin
         #1;
         checks++;
         if (bus.fsm_busy !== 1'b1) begin
            errors++; $display("FAIL busy rc=%0d got=%b exp=1", rc, bus.fsm_busy);
         end
         checks++;
         if (bus.mem_read_en !== (rc < 8)) begin
            errors++; $display("FAIL req_strobe rc=%0d got=%b exp=%b", rc, bus.mem_read_en, rc < 8);
         end
         if (bus.mem_read_en === 1'b1 && exp_q.size() > 0) begin
            a = exp_q.pop_front();
            checks++;
            if (bus.mem_address !== a) begin
               errors++; $display("FAIL mem_address rc=%0d got=%h exp=%h", rc, bus.mem_address, a);
            end
            pend_a.push_back(a);
            pend_t.push_back(rc + lat - 1);
         end
         if (bus.fill_done === 1'b1) begin
            done    = 1'b1;
            done_at = rc;
            checks++;
            if (rc != exp_done) begin
               errors++; $display("FAIL done_cycle got=%0d exp=%0d", rc, exp_done);
            end
            checks++;
            if ({bus.tag_wen_w2, bus.tag_wen_w1} !== (way ? 2'b10 : 2'b01)) begin
               errors++; $display("FAIL tag_wen got=%b%b exp_way=%b", bus.tag_wen_w2, bus.tag_wen_w1, way);
            end
            checks++;
            if (bus.tag_out !== addr[15:10]) begin
               errors++; $display("FAIL tag_out got=%h exp=%h", bus.tag_out, addr[15:10]);
            end
         end else begin
            checks++;
            if ({bus.tag_wen_w2, bus.tag_wen_w1} !== 2'b00) begin
               errors++; $display("FAIL early_tag_wen rc=%0d got=%b%b exp=00", rc, bus.tag_wen_w2, bus.tag_wen_w1);
            end
         end
         #1;
         if (rc == 0) begin
            if (hold_miss) begin
               bus.miss_address = alt_addr;
               bus.victim_way   = ~way;
            end else begin
               bus.miss_detected = 1'b0;
            end
         end
         if (rst_after >= 0 && nret == rst_after) begin
            bus.mem_data_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({bus.mem_read_en, bus.data_wen_w1, bus.data_wen_w2, bus.tag_wen_w1, bus.tag_wen_w2,
                 bus.fsm_busy, bus.fill_done} !== 7'b0) begin
               errors++; $display("FAIL rst_strobes got=%b%b%b%b%b%b%b exp=0", bus.mem_read_en, bus.data_wen_w1,
                                  bus.data_wen_w2, bus.tag_wen_w1, bus.tag_wen_w2, bus.fsm_busy, bus.fill_done);
            end
            checks++;
            if (bus.block_enable !== 64'd0 || bus.word_enable !== 8'd0) begin
               errors++; $display("FAIL rst_enables got=%h/%h exp=0/0", bus.block_enable, bus.word_enable);
            end
            checks++;
            if (bus.data_out !== 16'd0 || bus.mem_address !== 16'd0) begin
               errors++; $display("FAIL rst_buses got=%h/%h exp=0/0", bus.data_out, bus.mem_address);
            end
            checks++;
            if (bus.fsm_state !== IDLE) begin
               errors++; $display("FAIL rst_state got=%0d exp=%0d", bus.fsm_state, IDLE);
            end
            rst = 1'b0;
            // A stray return right after the abort must not touch the arrays.
            bus.mem_data_valid = 1'b1;
            bus.mem_data       = 16'($urandom);
            #1;
            checks++;
            if ({bus.data_wen_w1, bus.data_wen_w2, bus.tag_wen_w1, bus.tag_wen_w2} !== 4'b0) begin
               errors++; $display("FAIL post_rst_write got=%b%b%b%b exp=0000", bus.data_wen_w1,
                                  bus.data_wen_w2, bus.tag_wen_w1, bus.tag_wen_w2);
            end
            bus.mem_data_valid = 1'b0;
            aborted = 1'b1;
         end else begin
            gate = (gap_mode == 0) || (gap_mode == 1 && gap_pat[rc % 7] == 1'b1) ||
                   (gap_mode == 2 && $urandom_range(0, 1) == 1);
            if (done) begin
               bus.mem_data_valid = 1'b1;
               bus.mem_data       = 16'($urandom);
            end else if (pend_t.size() > 0 && pend_t[0] <= rc && gate) begin
               bus.mem_data_valid = 1'b1;
               bus.mem_data       = 16'($urandom);
               ra = pend_a.pop_front();
               void'(pend_t.pop_front());
            end else begin
               bus.mem_data_valid = 1'b0;
            end
            #1;
            if (bus.mem_data_valid === 1'b1 && !done) begin
               checks++;
               if ({bus.data_wen_w2, bus.data_wen_w1} !== (way ? 2'b10 : 2'b01)) begin
                  errors++; $display("FAIL data_wen rc=%0d got=%b%b exp_way=%b", rc, bus.data_wen_w2, bus.data_wen_w1, way);
               end
               checks++;
               if (bus.data_out !== bus.mem_data) begin
                  errors++; $display("FAIL data_out rc=%0d got=%h exp=%h", rc, bus.data_out, bus.mem_data);
               end
               checks++;
               if (bus.word_enable !== (8'd1 << ra[3:1])) begin
                  errors++; $display("FAIL word_enable rc=%0d got=%h exp=%h", rc, bus.word_enable, 8'd1 << ra[3:1]);
               end
               checks++;
               if (bus.block_enable !== (64'd1 << addr[9:4])) begin
                  errors++; $display("FAIL block_enable rc=%0d got=%h exp=%h", rc, bus.block_enable, 64'd1 << addr[9:4]);
               end
               nret++;
               // Last return during the final request goes straight to DONE; otherwise one WAIT cycle sees the count.
               if (nret == 8) exp_done = (rc == 7) ? 8 : rc + 2;
            end else begin
               checks++;
               if ({bus.data_wen_w2, bus.data_wen_w1} !== 2'b00 || bus.word_enable !== 8'd0) begin
                  errors++; $display("FAIL idle_write rc=%0d got=%b%b/%h exp=00/00", rc, bus.data_wen_w2,
                                     bus.data_wen_w1, bus.word_enable);
               end
            end
            @(posedge clk);
         end
      end
      if (!aborted) begin
         checks++;
         if (!done) begin
            errors++; $display("FAIL fill_timeout got=no_done exp=done");
         end
         #1;
         checks++;
         if ({bus.fsm_busy, bus.fill_done, bus.tag_wen_w1, bus.tag_wen_w2, bus.mem_read_en} !== 5'b0) begin
            errors++; $display("FAIL after_done got=%b%b%b%b%b exp=00000", bus.fsm_busy, bus.fill_done,
                               bus.tag_wen_w1, bus.tag_wen_w2, bus.mem_read_en);
         end
         #1;
         bus.mem_data_valid = 1'b1;
         bus.mem_data       = 16'($urandom);
         #1;
         checks++;
         if ({bus.data_wen_w1, bus.data_wen_w2} !== 2'b00 || bus.block_enable !== 64'd0 ||
             bus.word_enable !== 8'd0) begin
            errors++; $display("FAIL idle_return got=%b%b/%h/%h exp=00/0/0", bus.data_wen_w1, bus.data_wen_w2,
                               bus.block_enable, bus.word_enable);
         end
         bus.mem_data_valid = 1'b0;
         checks++;
         if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_requests got=%0d exp=0", exp_q.size());
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.miss_detected  = 1'b0;
      bus.miss_address   = '0;
      bus.victim_way     = 1'b0;
      bus.mem_data_valid = 1'b0;
      bus.mem_data       = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.fsm_state !== IDLE) begin
         errors++; $display("FAIL reset_state got=%0d exp=%0d", bus.fsm_state, IDLE);
      end
      checks++;
      if ({bus.mem_read_en, bus.data_wen_w1, bus.data_wen_w2, bus.tag_wen_w1, bus.tag_wen_w2,
           bus.fsm_busy, bus.fill_done} !== 7'b0) begin
         errors++; $display("FAIL reset_strobes got=%b%b%b%b%b%b%b exp=0", bus.mem_read_en, bus.data_wen_w1,
                            bus.data_wen_w2, bus.tag_wen_w1, bus.tag_wen_w2, bus.fsm_busy, bus.fill_done);
      end
      checks++;
      if (bus.block_enable !== 64'd0 || bus.word_enable !== 8'd0 || bus.data_out !== 16'd0 ||
          bus.mem_address !== 16'd0) begin
         errors++; $display("FAIL reset_buses got=%h/%h/%h/%h exp=0", bus.block_enable, bus.word_enable,
                            bus.data_out, bus.mem_address);
      end
      rst = 1'b0;
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 16'hBEEF;
      #1;
      checks++;
      if ({bus.data_wen_w1, bus.data_wen_w2} !== 2'b00 || bus.word_enable !== 8'd0) begin
         errors++; $display("FAIL spurious_idle got=%b%b/%h exp=00/00", bus.data_wen_w1, bus.data_wen_w2, bus.word_enable);
      end
      @(posedge clk);
      #1;
      bus.mem_data_valid = 1'b0;
      checks++;
      if (bus.fsm_state !== IDLE) begin
         errors++; $display("FAIL spurious_state got=%0d exp=%0d", bus.fsm_state, IDLE);
      end
   endtask

   task automatic test_way1_lat4();
      int done_at;
      do_fill(16'h1A36, 1'b0, 4, 0, 1'b0, 16'h0, -1, done_at);
      checks++;
      if (done_at + 1 != 13) begin
         errors++; $display("FAIL lat4_done got=%0d exp=13", done_at + 1);
      end
   endtask

   task automatic test_way2_lat1();
      int done_at;
      do_fill(16'h1A36, 1'b1, 1, 0, 1'b0, 16'h0, -1, done_at);
      checks++;
      if (done_at + 1 != 9) begin
         errors++; $display("FAIL lat1_done got=%0d exp=9", done_at + 1);
      end
   endtask

   task automatic test_gaps();
      int done_at;
      do_fill(16'h4C92, 1'b0, 2, 1, 1'b0, 16'h0, -1, done_at);
   endtask

   task automatic test_hold_miss();
      int done_at;
      do_fill(16'h1A36, 1'b1, 3, 0, 1'b1, 16'hFFFE, -1, done_at);
      @(posedge clk);
      #1;
      checks++;
      if (bus.mem_read_en !== 1'b1 || bus.mem_address !== 16'hFFF0) begin
         errors++; $display("FAIL held_miss_accept got=%b/%h exp=1/fff0", bus.mem_read_en, bus.mem_address);
      end
      bus.miss_detected = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset_midfill();
      int done_at;
      do_fill(16'h7B28, 1'b0, 2, 0, 1'b0, 16'h0, 3, done_at);
      do_fill(16'h7B28, 1'b0, 2, 0, 1'b0, 16'h0, -1, done_at);
   endtask

   task automatic test_random();
      int done_at;
      for (int n = 0; n < 8; n++) begin
         do_fill(16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 5),
                 $urandom_range(0, 2), 1'b0, 16'h0, -1, done_at);
      end
   endtask

   initial begin
      test_reset();
      test_way1_lat4();
      test_way2_lat1();
      test_gaps();
      test_hold_miss();
      test_reset_midfill();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
